alien_fleet_controller: RTL and testbench

Generates the on-screen positions of the 15-alien formation (3 rows × 5 columns) for `color_mapper`. It sits directly upstream of `color_mapper` and drives its `AlienX/AlienY/Alien_sizeX/Alien_sizeY` arrays. The formation is stepped horizontally once every `FRAME_DIV` video frames. At a screen edge the formation drops one row-step, reverses direction, and halts with a sticky `Invaded` flag once it reaches the invasion line. Position updates happen only at the start of vertical sync, so a frame is never drawn with a half-moved fleet.

---
 rtl/alien_fleet_controller.sv | 135 +++++++++++++
 tb/tb_alien_fleet_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet_controller.sv
// Formation position generator for the 3x5 alien fleet: steps the shared origin
// once every FRAME_DIV vsync falls, drops and reverses at screen edges, halts on invasion.
module alien_fleet_controller #(
  parameter int ALIEN_W   = 32,
  parameter int ALIEN_H   = 24,
  parameter int GAP_X     = 16,
  parameter int GAP_Y     = 16,
  parameter int START_X   = 64,
  parameter int START_Y   = 40,
  parameter int STEP_X    = 4,
  parameter int DROP_Y    = 12,
  parameter int FRAME_DIV = 8,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_LIMIT   = 400
) (
  input  logic       pixel_clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       enable,
  output logic [9:0] AlienX      [15],
  output logic [9:0] AlienY      [15],
  output logic [9:0] Alien_sizeX [15],
  output logic [9:0] Alien_sizeY [15],
  output logic       step_pulse,
  output logic       Invaded
);

  // state  | meaning
  // MOVE_R | fleet stepping right, drops and turns left at right bound
  // MOVE_L | fleet stepping left, drops and turns right at left bound
  // HALT   | invasion line reached, frozen until Reset

  localparam int FLEET_W = 5 * ALIEN_W + 4 * GAP_X;
  localparam int FLEET_H = 3 * ALIEN_H + 2 * GAP_Y;
  localparam int CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {MOVE_R, MOVE_L, HALT} state_e;

  state_e           state_q, state_d;
  logic [9:0]       origin_x_q, origin_x_d;
  logic [9:0]       origin_y_q, origin_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vs_q, armed_q, frame_tick_q;
  logic             step_pulse_q, invaded_q, invaded_d;

  logic [10:0] ox_w, right_sum, y_drop;
  logic        hit_right, hit_left, invade, cnt_last, do_step;

  assign ox_w      = {1'b0, origin_x_q};
  assign right_sum = ox_w + 11'(FLEET_W + STEP_X);
  assign hit_right = right_sum > 11'(X_MAX + 1);
  assign hit_left  = ox_w < 11'(X_MIN + STEP_X);
  assign y_drop    = {1'b0, origin_y_q} + 11'(DROP_Y);
  assign invade    = (y_drop + 11'(FLEET_H)) >= 11'(Y_LIMIT);
  assign cnt_last  = (cnt_q == CNT_W'(FRAME_DIV - 1));
  assign do_step   = frame_tick_q & enable & cnt_last & (state_q != HALT);

  always_comb begin
    state_d    = state_q;
    origin_x_d = origin_x_q;
    origin_y_d = origin_y_q;
    invaded_d  = invaded_q;
    cnt_d      = cnt_q;
    if (frame_tick_q && enable) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
    end
    if (do_step) begin
      case (state_q)
        MOVE_R: begin
          if (hit_right) begin
            origin_y_d = y_drop[9:0];
            state_d    = MOVE_L;
          end else begin
            origin_x_d = origin_x_q + 10'(STEP_X);
          end
        end
        MOVE_L: begin
          if (hit_left) begin
            origin_y_d = y_drop[9:0];
            state_d    = MOVE_R;
          end else begin
            origin_x_d = origin_x_q - 10'(STEP_X);
          end
        end
        default: ;
      endcase
      // the drop itself is kept even when it lands on the invasion line
      if (((state_q == MOVE_R) && hit_right) || ((state_q == MOVE_L) && hit_left)) begin
        if (invade) begin
          state_d   = HALT;
          invaded_d = 1'b1;
        end
      end
    end
  end

  // armed_q blocks a tick when vs is already low as Reset releases
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      vs_q         <= 1'b1;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      cnt_q        <= '0;
      state_q      <= MOVE_R;
      origin_x_q   <= 10'(START_X);
      origin_y_q   <= 10'(START_Y);
      step_pulse_q <= 1'b0;
      invaded_q    <= 1'b0;
    end else begin
      vs_q         <= vs;
      armed_q      <= armed_q | vs;
      frame_tick_q <= vs_q & ~vs & armed_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      origin_x_q   <= origin_x_d;
      origin_y_q   <= origin_y_d;
      step_pulse_q <= do_step;
      invaded_q    <= invaded_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign Invaded    = invaded_q;

  for (genvar i = 0; i < 15; i++) begin : g_alien
    localparam int COL = i % 5;
    localparam int ROW = i / 5;
    assign AlienX[i]      = origin_x_q + 10'(COL * (ALIEN_W + GAP_X));
    assign AlienY[i]      = origin_y_q + 10'(ROW * (ALIEN_H + GAP_Y));
    assign Alien_sizeX[i] = 10'(ALIEN_W);
    assign Alien_sizeY[i] = 10'(ALIEN_H);
  end

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Directed bench for alien_fleet_controller with default parameters:
// reset, frame divider, pause, both edges, invasion and mid-run reset.
module tb_alien_fleet_controller;

  logic       clk;
  logic       rst;
  logic       vs;
  logic       enable;
  logic [9:0] ax [15];
  logic [9:0] ay [15];
  logic [9:0] sx [15];
  logic [9:0] sy [15];
  logic       step_pulse;
  logic       invaded;

  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;

  alien_fleet_controller dut (
    .pixel_clk   (clk),
    .Reset       (rst),
    .vs          (vs),
    .enable      (enable),
    .AlienX      (ax),
    .AlienY      (ay),
    .Alien_sizeX (sx),
    .Alien_sizeY (sy),
    .step_pulse  (step_pulse),
    .Invaded     (invaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic fall(input int low_cycles = 1);
    @(negedge clk) vs = 1'b0;
    repeat (low_cycles - 1) @(negedge clk);
    @(negedge clk) vs = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_steps(input int n);
    repeat (n) begin
      repeat (8) fall();
      settle();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b0; enable = 1'b1;
    #2;
    chk("rst_x0", int'(ax[0]), 64);
    chk("rst_y0", int'(ay[0]), 40);
    chk("rst_x4", int'(ax[4]), 256);
    chk("rst_y14", int'(ay[14]), 120);
    chk("rst_inv", int'(invaded), 0);
    chk("rst_pulse", int'(step_pulse), 0);
    chk("size_x", int'(sx[7]), 32);
    chk("size_y", int'(sy[13]), 24);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    settle();
  endtask

  task automatic test_frame_div();
    int p0;
    p0 = pulse_cnt;
    fall(10);
    repeat (6) fall();
    settle();
    chk("div7_x0", int'(ax[0]), 64);
    chk("div7_pulses", pulse_cnt, p0);
    @(negedge clk) vs = 1'b0;
    @(negedge clk) vs = 1'b1;
    chk("div_tick_x0", int'(ax[0]), 64);
    chk("div_tick_pulse", int'(step_pulse), 0);
    @(negedge clk);
    chk("div_step_x0", int'(ax[0]), 68);
    chk("div_step_y0", int'(ay[0]), 40);
    chk("div_step_pulse", int'(step_pulse), 1);
    @(negedge clk);
    chk("div_pulse_low", int'(step_pulse), 0);
    chk("div_pulse_cnt", pulse_cnt, p0 + 1);
  endtask

  task automatic test_pause();
    int p0;
    repeat (5) fall();
    settle();
    p0 = pulse_cnt;
    enable = 1'b0;
    repeat (20) fall();
    settle();
    chk("pause_x0", int'(ax[0]), 68);
    chk("pause_pulses", pulse_cnt, p0);
    enable = 1'b1;
    repeat (2) fall();
    settle();
    chk("resume2_x0", int'(ax[0]), 68);
    fall();
    settle();
    chk("resume3_x0", int'(ax[0]), 72);
    chk("resume_pulses", pulse_cnt, p0 + 1);
  endtask

  task automatic test_right_edge();
    int p0;
    p0 = pulse_cnt;
    do_steps(86);
    chk("r88_x0", int'(ax[0]), 416);
    chk("r88_y0", int'(ay[0]), 40);
    chk("r88_pulses", pulse_cnt, p0 + 86);
    do_steps(1);
    chk("r89_x0", int'(ax[0]), 416);
    chk("r89_y0", int'(ay[0]), 52);
    chk("r89_x4", int'(ax[4]), 608);
    chk("r89_y14", int'(ay[14]), 132);
    do_steps(1);
    chk("r90_x0", int'(ax[0]), 412);
  endtask

  task automatic test_left_edge();
    do_steps(103);
    chk("l_x0", int'(ax[0]), 0);
    chk("l_y0", int'(ay[0]), 52);
    do_steps(1);
    chk("ldrop_x0", int'(ax[0]), 0);
    chk("ldrop_y0", int'(ay[0]), 64);
    do_steps(1);
    chk("lturn_x0", int'(ax[0]), 4);
    chk("lturn_inv", int'(invaded), 0);
  endtask

  task automatic test_invasion();
    int  k;
    int  p0;
    bit  hit;
    k = 0;
    hit = 1'b0;
    while (k < 2200 && !hit) begin
      do_steps(1);
      k++;
      if (invaded === 1'b1) hit = 1'b1;
    end
    chk("inv_seen", int'(hit), 1);
    chk("inv_steps", k, 2099);
    chk("inv_y0", int'(ay[0]), 304);
    chk("inv_x0", int'(ax[0]), 0);
    chk("inv_y14", int'(ay[14]), 384);
    p0 = pulse_cnt;
    repeat (16) fall();
    settle();
    chk("halt_pulses", pulse_cnt, p0);
    chk("halt_x0", int'(ax[0]), 0);
    chk("halt_y0", int'(ay[0]), 304);
    chk("halt_inv", int'(invaded), 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_x0", int'(ax[0]), 64);
    chk("mrst_y0", int'(ay[0]), 40);
    chk("mrst_x4", int'(ax[4]), 256);
    chk("mrst_y14", int'(ay[14]), 120);
    chk("mrst_inv", int'(invaded), 0);
    chk("mrst_pulse", int'(step_pulse), 0);
    @(negedge clk) rst = 1'b0;
    settle();
    do_steps(1);
    chk("mrst_step_x0", int'(ax[0]), 68);
    chk("mrst_step_y0", int'(ay[0]), 40);
  endtask

  initial begin
    test_reset();
    test_frame_div();
    test_pause();
    test_right_edge();
    test_left_edge();
    test_invasion();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
